// File: rtl/rev_sensor_encoder_if.sv
// rev_sensor_encoder_if: engine sensor pins in, revolution zone / ignition results out
interface rev_sensor_encoder_if #(parameter int CNT_W = 12);
  logic             tach_in;
  logic             key_in;
  logic [1:0]       R;
  logic             A;
  logic             R_valid;
  logic [CNT_W-1:0] pulse_count;
  modport master (input tach_in, key_in, output R, A, R_valid, pulse_count);
  modport slave (output tach_in, key_in, input R, A, R_valid, pulse_count);
endinterface

// File: rtl/rev_sensor_encoder.sv
// rev_sensor_encoder: windowed tach pulse counter with hysteretic RPM zones and debounced ignition
module rev_sensor_encoder #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 12,
  parameter int TH1           = 10,
  parameter int TH2           = 25,
  parameter int TH3           = 40,
  parameter int HYST          = 2,
  parameter int DEB_CYCLES    = 16
) (
  input logic clk,
  input logic reset,
  rev_sensor_encoder_if.master bus
);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAXC = '1;
  logic [1:0] tach_sync, key_sync;
  logic tach_prev, a, valid;
  logic [DW-1:0] deb_cnt;
  logic [WW-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt, pc, final_cnt;
  logic [1:0] r, up_zone, dn_zone, next_r;
  logic tach_edge, key_diff, a_flip, run, win_end;
  function automatic logic [1:0] zone(input int c);
    return c >= TH3 ? 2'd3 : c >= TH2 ? 2'd2 : c >= TH1 ? 2'd1 : 2'd0;
  endfunction
  // a window closing on the same edge that A falls is discarded: A wins
  always_comb begin
    tach_edge = tach_sync[1] & ~tach_prev;
    key_diff  = key_sync[1] ^ a;
    a_flip    = key_diff && deb_cnt == DW'(DEB_CYCLES - 1);
    run       = a & ~a_flip;
    win_end   = run && win_cnt == WW'(WINDOW_CYCLES - 1);
    final_cnt = edge_cnt == MAXC ? MAXC : edge_cnt + CNT_W'(tach_edge);
    up_zone   = zone(int'(final_cnt));
    dn_zone   = zone(int'(final_cnt) + HYST);
    next_r    = up_zone > r ? up_zone : dn_zone < r ? dn_zone : r;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tach_sync <= '0;
      key_sync  <= '0;
      tach_prev <= 1'b0;
      deb_cnt   <= '0;
      a         <= 1'b0;
      valid     <= 1'b0;
      win_cnt   <= '0;
      edge_cnt  <= '0;
      pc        <= '0;
      r         <= '0;
    end else begin
      tach_sync <= {tach_sync[0], bus.tach_in};
      key_sync  <= {key_sync[0], bus.key_in};
      tach_prev <= tach_sync[1];
      deb_cnt   <= key_diff && !a_flip ? deb_cnt + 1'b1 : '0;
      a         <= a ^ a_flip;
      valid     <= win_end;
      if (!run) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        pc       <= '0;
        r        <= '0;
      end else if (win_end) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        pc       <= final_cnt;
        r        <= next_r;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= final_cnt;
      end
    end
  end
  assign bus.R           = r;
  assign bus.A           = a;
  assign bus.R_valid     = valid;
  assign bus.pulse_count = pc;
endmodule

// File: tb/tb_rev_sensor_encoder.sv
// tb_rev_sensor_encoder: directed + random windows checked every cycle against an input-history reference model
module tb_rev_sensor_encoder;
  localparam int W = 400, CW = 6, T1 = 10, T2 = 25, T3 = 40, HY = 2, DEB = 16, MAXC = 63;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  rev_sensor_encoder_if #(.CNT_W(CW)) bus();
  rev_sensor_encoder #(.WINDOW_CYCLES(W), .CNT_W(CW), .TH1(T1), .TH2(T2), .TH3(T3),
    .HYST(HY), .DEB_CYCLES(DEB)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, errors = 0;
  logic [3:1] mk, mt;
  logic m_a, m_v;
  int m_run, m_age, m_pulses, m_r, m_pc;
  function automatic int zone(input int c);
    int th[3] = '{T1, T2, T3};
    int z = 0;
    foreach (th[i]) if (c >= th[i]) z++;
    return z;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    mk = '0; mt = '0; m_a = 0; m_v = 0;
    m_run = 0; m_age = 0; m_pulses = 0; m_r = 0; m_pc = 0;
  endtask
  // raw inputs reach the logic two edges late; a tach edge is a 0->1 between consecutive synced samples
  task automatic model_update(input logic k, input logic t);
    logic sk, e, flip;
    int up, dn;
    sk = mk[2]; e = mt[2] & ~mt[3]; flip = 0; m_v = 0;
    if (sk != m_a) begin
      m_run++;
      if (m_run == DEB) begin flip = 1; m_run = 0; end
    end else m_run = 0;
    if (m_a && !flip) begin
      m_age++;
      m_pulses = m_pulses + int'(e) > MAXC ? MAXC : m_pulses + int'(e);
      if (m_age == W) begin
        up = zone(m_pulses); dn = zone(m_pulses + HY);
        m_r = up > m_r ? up : dn < m_r ? dn : m_r;
        m_pc = m_pulses; m_v = 1; m_age = 0; m_pulses = 0;
      end
    end else begin
      m_age = 0; m_pulses = 0; m_r = 0; m_pc = 0;
    end
    m_a = m_a ^ flip;
    mk = {mk[2:1], k}; mt = {mt[2:1], t};
  endtask
  task automatic step(input logic k, input logic t);
    bus.key_in = k; bus.tach_in = t;
    @(posedge clk);
    model_update(k, t);
    @(negedge clk);
    chk("R", bus.R, m_r);
    chk("A", bus.A, m_a);
    chk("R_valid", bus.R_valid, m_v);
    chk("pulse_count", bus.pulse_count, m_pc);
  endtask
  task automatic wait_a(input logic k, input logic want, output int n);
    n = 0;
    do begin step(k, 1'b0); n++; end while (bus.A !== want && n < 60);
  endtask
  task automatic do_window(input int n, input bit tog, input int exp_pc, input int exp_r, input bit fixed);
    for (int i = 0; i < W; i++) begin
      step(1'b1, tog ? logic'(i % 2) : logic'(i >= 10 && i < 10 + 6 * n && (i - 10) % 6 < 3));
      if (i == 0) chk("valid_width", bus.R_valid, 0);
    end
    chk("win_valid", bus.R_valid, 1);
    if (fixed) begin
      chk("win_pc", bus.pulse_count, exp_pc);
      chk("win_R", bus.R, exp_r);
    end
  endtask
  initial begin
    int n, quiet;
    bus.key_in = 0; bus.tach_in = 0;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_R", bus.R, 0);
    chk("rst_A", bus.A, 0);
    chk("rst_valid", bus.R_valid, 0);
    chk("rst_pc", bus.pulse_count, 0);
    model_reset();
    reset = 1;
    quiet = 0;
    for (int i = 0; i < 90; i++) begin
      step(logic'(i < 60 && (i / 5) % 2 == 0), 1'b0);
      quiet += int'(bus.A) + int'(bus.R_valid);
    end
    chk("bounce_quiet", quiet, 0);
    wait_a(1'b1, 1'b1, n);
    chk("ign_latency", n, 18);
    do_window(30, 0, 30, 2, 1);
    do_window(24, 0, 24, 2, 1);
    do_window(22, 0, 22, 1, 1);
    do_window(5, 0, 5, 0, 1);
    do_window(45, 0, 45, 3, 1);
    do_window(5, 0, 5, 0, 1);
    do_window(0, 1, MAXC, 3, 1);
    for (int i = 0; i < 200; i++) step(1'b1, logic'(i % 6 < 3));
    wait_a(1'b0, 1'b0, n);
    chk("off_latency", n, 18);
    chk("off_R", bus.R, 0);
    chk("off_pc", bus.pulse_count, 0);
    quiet = 0;
    for (int i = 0; i < W + 50; i++) begin
      step(1'b0, logic'(i % 2));
      quiet += int'(bus.A) + int'(bus.R_valid);
    end
    chk("off_quiet", quiet, 0);
    wait_a(1'b1, 1'b1, n);
    chk("reign_latency", n, 18);
    do_window(45, 0, 45, 3, 1);
    for (int i = 0; i < W; i++) step(logic'(i < W - 18), logic'(i < 300 && i % 6 < 3));
    chk("fall_valid", bus.R_valid, 0);
    chk("fall_A", bus.A, 0);
    chk("fall_R", bus.R, 0);
    wait_a(1'b1, 1'b1, n);
    do_window($urandom_range(0, 60), 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) step(1'b1, logic'(i % 6 < 3));
    #2 reset = 0;
    #1;
    chk("async_R", bus.R, 0);
    chk("async_A", bus.A, 0);
    chk("async_valid", bus.R_valid, 0);
    chk("async_pc", bus.pulse_count, 0);
    model_reset();
    repeat (4) begin @(negedge clk); bus.tach_in = ~bus.tach_in; end
    @(negedge clk);
    reset = 1; bus.tach_in = 0;
    wait_a(1'b1, 1'b1, n);
    chk("rst_ign_latency", n, 18);
    do_window(20, 0, 20, 1, 1);
    for (int j = 0; j < 6; j++) do_window($urandom_range(0, 60), 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
